bash_hash_ctrl: RTL and testbench
=================================

# bash_hash_ctrl

Message-side controller for the Bash hash core. It accepts a 64-bit word stream over valid/ready and packs it into rate-sized blocks. It applies Bash padding, sequences the core through prep/start plus 24 work cycles per block, and returns the digest over a valid/ready handshake. It sits between the system bus front-end and the hash core, and is the sole driver of the core's control and data inputs.

## Interface
- SLEN, 64, state word width (from package)
- XLEN, 2, level-select width (from package)
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; asynchronous, active-low
- level_i  in  XLEN  security level, sampled on first accepted beat: 0=128, 1=192, 2=256, 3 treated as 256
- in_valid_i  in  1  message word valid
- in_ready_o  out  1  controller accepts word
- in_data_i  in  SLEN  message word; byte k at bits [8k+7:8k]
- in_last_i  in  1  final beat of message
- in_nbytes_i  in  4  valid bytes in last beat, 0..8 (ignored unless last)
- core_prep_o  out  1  clear core capacity, load level constant
- core_start_o  out  1  load block into core
- core_work_o  out  1  advance core one step
- core_l_o  out  XLEN  latched level
- core_x_o  out  16*SLEN  block words, word i at [64i+63:64i]
- core_y_i  in  8*SLEN  core state words 0..7
- hash_valid_o  out  1  digest valid
- hash_ready_i  in  1  digest consumed
- hash_o  out  8*SLEN  digest; words ≥ 2l/64 driven zero

## Operation
- Rate R words: 16 (l=128), 12 (l=192), 8 (l=256). Digest words: 4, 6, 8.
- States: IDLE, FILL, PAD, LOAD, RUN, OUT.
- IDLE: in_ready_o=1. First handshake latches level_i, stores word 0, and moves to FILL, or to LOAD if the beat is last or R is reached.
- FILL: in_ready_o=1. Each handshake writes buffer[cnt] and increments cnt. cnt==R or last beat moves to LOAD.
- Last beat with nbytes<8: byte[nbytes]=8'h40, bytes above it zeroed. nbytes=0 gives word 64'h40.
- Last beat with nbytes=8 and cnt+1<R: the next word becomes 64'h40 within the same block.
- Last beat with nbytes=8 and block exactly full: set pad_pend. After RUN, go to PAD, which builds a block with word0=64'h40 and the rest zero in one cycle, then LOAD.
- Buffer words at index ≥ words written are driven zero on core_x_o.
- LOAD: core_start_o=1 for one cycle. core_prep_o=1 in the same cycle for the first block of a message only.
- RUN: core_work_o=1 for exactly 24 cycles, tracked by a 5-bit round counter. At the end:
  - go to PAD if pad_pend;
  - go to OUT if the final block is done;
  - otherwise clear cnt and go to FILL.
- OUT: hash_valid_o=1 and hash_o=core_y_i masked. The core holds its state because no enable is asserted. The handshake returns to IDLE.
- in_ready_o=0 in LOAD, RUN, PAD and OUT (single buffer).
- Reset asserted in any state: IDLE, all outputs 0, counters and pad_pend cleared, buffer contents don't-care.

## Timing
- Reset values: in_ready_o=0 while rst_ni=0 and 1 from the first cycle after release. All other outputs are 0.
- Block accepted at cycle t, then:
  - LOAD at t+1;
  - work at t+2..t+25;
  - if final, hash_valid_o at t+26.
- Each extra block adds 25 cycles (FILL words + LOAD + 24). PAD adds 1 cycle.
- hash_valid_o stays high with hash_o stable until hash_ready_i. IDLE is entered the cycle after the handshake.
- core_start_o and core_work_o are never high in the same cycle.

## Structure
- Extend bash_hash_params_pkg with:
  - BASH_ROUNDS=24;
  - BASH_PAD_BYTE=8'h40;
  - level typedef/enum;
  - rate and digest-word lookup functions;
  - state enum.
- One sub-module, bash_pad_word: a combinational unit that takes (data, nbytes) and returns the masked word with the pad byte inserted.

## Test plan
- Empty message, l=128: one beat last, nbytes=0 → core_x_o word0=64'h40 and others 0; prep+start at t+1; 24 work cycles; hash_valid_o at t+26.
- l=256, one beat 64'h030201, nbytes=3 → word0=64'h0000_0000_4003_0201; single block.
- l=128, 16 full words, last nbytes=8 → two blocks; second has word0=64'h40; prep only on first start; valid 52 cycles after last beat.
- l=192, 12 words then 1 word (last nbytes=8) → second block word0=data, word1=64'h40; digest words 6..7 zero.
- hash_ready_i held low 10 cycles → hash_valid_o and hash_o stable; in_ready_o=0 throughout.
- rst_ni dropped at round 12 of RUN → core_work_o falls asynchronously; after release the next message hashes identically to a fresh run.

Source files
------------

// File: rtl/bash_hash_params_pkg.sv
// Shared parameters, enums and lookup helpers for the Bash hash message controller.
package bash_hash_params_pkg;

  localparam int SLEN        = 64;  // state word width
  localparam int XLEN        = 2;   // level-select width
  localparam int BASH_ROUNDS = 24;  // core work cycles per block
  localparam int MAX_RATE    = 16;  // largest block, in words (l=128)
  localparam int DIGEST_MAX  = 8;   // largest digest, in words (l=256)

  localparam logic [7:0] BASH_PAD_BYTE = 8'h40;

  typedef enum logic [XLEN-1:0] {
    LVL_128     = 2'd0,
    LVL_192     = 2'd1,
    LVL_256     = 2'd2,
    LVL_256_ALT = 2'd3
  } bash_level_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_LOAD,
    ST_RUN,
    ST_OUT
  } ctrl_state_e;

  // Level code 3 is an alias for 256 so the core only ever sees 0..2.
  function automatic logic [XLEN-1:0] norm_level(input logic [XLEN-1:0] lvl);
    return (lvl == LVL_256_ALT) ? LVL_256 : lvl;
  endfunction

  // Block size in 64-bit words for a given level.
  function automatic logic [4:0] rate_words(input logic [XLEN-1:0] lvl);
    case (lvl)
      LVL_128: return 5'd16;
      LVL_192: return 5'd12;
      default: return 5'd8;
    endcase
  endfunction

  // Digest length in 64-bit words for a given level.
  function automatic logic [3:0] digest_words(input logic [XLEN-1:0] lvl);
    case (lvl)
      LVL_128: return 4'd4;
      LVL_192: return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/bash_pad_word.sv
// Masks the final message word to its valid bytes and inserts the Bash pad byte
// right after them. With 8 valid bytes the word passes through unchanged.
module bash_pad_word
  import bash_hash_params_pkg::*;
(
  input  logic [SLEN-1:0] data_i,
  input  logic [3:0]      nbytes_i,
  output logic [SLEN-1:0] word_o
);

  genvar gi;
  generate
    for (gi = 0; gi < SLEN / 8; gi++) begin : g_byte
      localparam logic [3:0] BYTE_IDX = 4'(gi);
      assign word_o[8*gi +: 8] = (nbytes_i > BYTE_IDX)  ? data_i[8*gi +: 8] :
                                 (nbytes_i == BYTE_IDX) ? BASH_PAD_BYTE     :
                                                          8'h00;
    end
  endgenerate

endmodule

// File: rtl/bash_hash_ctrl.sv
// Message-side controller for the Bash hash core: packs a 64-bit word stream into
// rate-sized blocks, applies padding, drives prep/start/work, returns the digest.
module bash_hash_ctrl
  import bash_hash_params_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [XLEN-1:0]        level_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [SLEN-1:0]        in_data_i,
  input  logic                   in_last_i,
  input  logic [3:0]             in_nbytes_i,
  output logic                   core_prep_o,
  output logic                   core_start_o,
  output logic                   core_work_o,
  output logic [XLEN-1:0]        core_l_o,
  output logic [16*SLEN-1:0]     core_x_o,
  input  logic [8*SLEN-1:0]      core_y_i,
  output logic                   hash_valid_o,
  input  logic                   hash_ready_i,
  output logic [8*SLEN-1:0]      hash_o
);

  ctrl_state_e     state_reg;
  logic [4:0]      cnt_reg;       // words written into the current block
  logic [4:0]      round_reg;
  logic [XLEN-1:0] level_reg;
  logic            pad_pend_reg;  // pad needs its own block after this one
  logic            final_reg;     // current block is the last of the message
  logic            first_reg;     // current block is the first of the message
  logic            in_ready_reg;
  logic            start_reg;
  logic            prep_reg;
  logic            work_reg;
  logic            hash_valid_reg;

  logic            acc;
  logic [XLEN-1:0] cur_level;
  logic [4:0]      cur_rate;
  logic [4:0]      cnt_inc;
  logic            is_full_beat;
  logic            room_for_pad;
  logic            extra_pad;
  logic            pad_pend_set;
  logic            block_done;
  logic [SLEN-1:0] pad_data;
  logic [SLEN-1:0] beat_word;
  logic            wr_en;
  logic [4:0]      wr_idx;
  logic [SLEN-1:0] wr_data;
  logic [3:0]      dig_words;

  // In IDLE the level is not latched yet, so the block size follows level_i.
  assign acc          = in_valid_i & in_ready_reg;
  assign cur_level    = (state_reg == ST_IDLE) ? norm_level(level_i) : level_reg;
  assign cur_rate     = rate_words(cur_level);
  assign cnt_inc      = cnt_reg + 5'd1;
  assign is_full_beat = (in_nbytes_i >= 4'd8);
  assign room_for_pad = (cnt_inc < cur_rate);
  assign extra_pad    = acc & in_last_i & is_full_beat & room_for_pad;
  assign pad_pend_set = acc & in_last_i & is_full_beat & ~room_for_pad;
  assign block_done   = acc & (in_last_i | ~room_for_pad);
  assign beat_word    = in_last_i ? pad_data : in_data_i;
  assign dig_words    = digest_words(level_reg);

  bash_pad_word u_pad (
    .data_i   (in_data_i),
    .nbytes_i (in_nbytes_i),
    .word_o   (pad_data)
  );

  // Select the primary buffer write: an accepted beat, or the standalone pad block.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = cnt_reg;
    wr_data = beat_word;
    if (state_reg == ST_PAD) begin
      wr_en   = 1'b1;
      wr_idx  = 5'd0;
      wr_data = {{(SLEN-8){1'b0}}, BASH_PAD_BYTE};
    end else if (acc) begin
      wr_en = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_RATE; gi++) begin : g_buf
      localparam logic [4:0] WORD_IDX = 5'(gi);
      logic [SLEN-1:0] word_reg;

      // Block buffer word; a full last beat may also drop the pad word one slot up.
      always_ff @(posedge clk_i) begin
        if (wr_en && (wr_idx == WORD_IDX)) begin
          word_reg <= wr_data;
        end else if (extra_pad && (cnt_inc == WORD_IDX)) begin
          word_reg <= {{(SLEN-8){1'b0}}, BASH_PAD_BYTE};
        end
      end

      // Slots not written for this block read as zero, so stale data never leaks.
      assign core_x_o[SLEN*gi +: SLEN] = (WORD_IDX < cnt_reg) ? word_reg : '0;
    end

    for (gi = 0; gi < DIGEST_MAX; gi++) begin : g_hash
      localparam logic [3:0] DIG_IDX = 4'(gi);
      assign hash_o[SLEN*gi +: SLEN] = (hash_valid_reg && (DIG_IDX < dig_words)) ?
                                       core_y_i[SLEN*gi +: SLEN] : '0;
    end
  endgenerate

  // Control FSM; every control output is registered alongside the state change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      round_reg      <= '0;
      level_reg      <= '0;
      pad_pend_reg   <= 1'b0;
      final_reg      <= 1'b0;
      first_reg      <= 1'b0;
      in_ready_reg   <= 1'b0;
      start_reg      <= 1'b0;
      prep_reg       <= 1'b0;
      work_reg       <= 1'b0;
      hash_valid_reg <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      prep_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_FILL: begin
          in_ready_reg <= 1'b1;
          if (acc) begin
            if (state_reg == ST_IDLE) begin
              level_reg <= cur_level;
              first_reg <= 1'b1;
            end
            cnt_reg      <= extra_pad ? (cnt_reg + 5'd2) : cnt_inc;
            pad_pend_reg <= pad_pend_set;
            final_reg    <= in_last_i & ~pad_pend_set;
            if (block_done) begin
              state_reg    <= ST_LOAD;
              in_ready_reg <= 1'b0;
              start_reg    <= 1'b1;
              prep_reg     <= (state_reg == ST_IDLE) | first_reg;
            end else begin
              state_reg <= ST_FILL;
            end
          end
        end
        ST_LOAD: begin
          state_reg <= ST_RUN;
          work_reg  <= 1'b1;
          round_reg <= '0;
          first_reg <= 1'b0;
        end
        ST_RUN: begin
          round_reg <= round_reg + 5'd1;
          if (round_reg == 5'(BASH_ROUNDS - 1)) begin
            work_reg <= 1'b0;
            if (pad_pend_reg) begin
              state_reg <= ST_PAD;
            end else if (final_reg) begin
              state_reg      <= ST_OUT;
              hash_valid_reg <= 1'b1;
            end else begin
              state_reg    <= ST_FILL;
              cnt_reg      <= '0;
              in_ready_reg <= 1'b1;
            end
          end
        end
        ST_PAD: begin
          state_reg    <= ST_LOAD;
          start_reg    <= 1'b1;
          cnt_reg      <= 5'd1;
          pad_pend_reg <= 1'b0;
          final_reg    <= 1'b1;
        end
        ST_OUT: begin
          if (hash_ready_i) begin
            state_reg      <= ST_IDLE;
            hash_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
            cnt_reg        <= '0;
            final_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_reg;
  assign core_start_o = start_reg;
  assign core_prep_o  = prep_reg;
  assign core_work_o  = work_reg;
  assign core_l_o     = level_reg;
  assign hash_valid_o = hash_valid_reg;

endmodule

// File: tb/tb_bash_hash_ctrl.sv
// Directed bench for bash_hash_ctrl with a static stand-in for the core state.
module tb_bash_hash_ctrl;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [1:0]     level_i = '0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  logic [63:0]    in_data_i = '0;
  logic           in_last_i = 1'b0;
  logic [3:0]     in_nbytes_i = '0;
  logic           core_prep_o;
  logic           core_start_o;
  logic           core_work_o;
  logic [1:0]     core_l_o;
  logic [1023:0]  core_x_o;
  logic [511:0]   core_y_i;
  logic           hash_valid_o;
  logic           hash_ready_i = 1'b0;
  logic [511:0]   hash_o;

  int total = 0;
  int bad   = 0;

  // monitor state
  int          ncyc = 0;
  int          nstart = 0;
  int          nwork = 0;
  int          nboth = 0;
  int          last_t = -1;
  int          valid_t = -1;
  int          start_t [0:3];
  logic        prep_at [0:3];
  logic [63:0] xs [0:3][0:15];

  logic [63:0] msg   [0:31];
  logic [63:0] exp_x [0:2][0:15];

  always #5 clk_i = ~clk_i;

  bash_hash_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .level_i      (level_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .in_last_i    (in_last_i),
    .in_nbytes_i  (in_nbytes_i),
    .core_prep_o  (core_prep_o),
    .core_start_o (core_start_o),
    .core_work_o  (core_work_o),
    .core_l_o     (core_l_o),
    .core_x_o     (core_x_o),
    .core_y_i     (core_y_i),
    .hash_valid_o (hash_valid_o),
    .hash_ready_i (hash_ready_i),
    .hash_o       (hash_o)
  );

  function automatic logic [63:0] y_word(input int i);
    return {8'hC0 + 8'(i), 56'h01_2345_6789_ABCD};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) core_y_i[64*i +: 64] = y_word(i);
  end

  // Sample control activity on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    ncyc = ncyc + 1;
    if (in_valid_i && in_ready_o && in_last_i) last_t = ncyc;
    if (core_start_o) begin
      if (nstart < 4) begin
        start_t[nstart] = ncyc;
        prep_at[nstart] = core_prep_o;
        for (int i = 0; i < 16; i++) xs[nstart][i] = core_x_o[64*i +: 64];
      end
      nstart = nstart + 1;
    end
    if (core_work_o) nwork = nwork + 1;
    if (core_start_o && core_work_o) nboth = nboth + 1;
    if (hash_valid_o && valid_t < 0) valid_t = ncyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    nstart = 0; nwork = 0; nboth = 0; last_t = -1; valid_t = -1;
  endtask

  task automatic clear_exp();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 16; i++) exp_x[b][i] = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [63:0] d, input logic last,
                           input logic [3:0] nb, input logic [1:0] lvl);
    int g;
    in_valid_i = 1'b1; in_data_i = d; in_last_i = last;
    in_nbytes_i = nb; level_i = lvl;
    g = 0;
    while (!in_ready_o && g < 300) begin
      @(posedge clk_i); #1; g++;
    end
    if (g >= 300) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; in_last_i = 1'b0;
  endtask

  task automatic send_msg(input int lvl, input int nw, input int nb);
    for (int i = 0; i < nw; i++)
      send_beat(msg[i], (i == nw - 1), (i == nw - 1) ? 4'(nb) : 4'd8, 2'(lvl));
  endtask

  task automatic run_msg(input string name, input int lvl, input int nw, input int nb,
                         input int exp_blocks, input int exp_lat, input int exp_ls,
                         input int exp_dw, input int hold);
    int g;
    clear_mon();
    send_msg(lvl, nw, nb);
    g = 0;
    while (!hash_valid_o && g < 200) begin
      @(posedge clk_i); #1; g++;
    end
    chk({name, "_valid"}, 64'(hash_valid_o), 64'd1);
    chk({name, "_core_l"}, 64'(core_l_o), 64'((lvl == 3) ? 2 : lvl));
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_hash%0d", name, i), hash_o[64*i +: 64],
          (i < exp_dw) ? y_word(i) : 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_i); #1;
      chk($sformatf("%s_hold_valid%0d", name, h), 64'(hash_valid_o), 64'd1);
      chk($sformatf("%s_hold_hash%0d", name, h), hash_o[63:0], y_word(0));
      chk($sformatf("%s_hold_rdy%0d", name, h), 64'(in_ready_o), 64'd0);
    end
    hash_ready_i = 1'b1;
    @(posedge clk_i); #1;
    hash_ready_i = 1'b0;
    chk({name, "_valid_drop"}, 64'(hash_valid_o), 64'd0);
    chk({name, "_idle_rdy"}, 64'(in_ready_o), 64'd1);
    chk({name, "_latency"}, 64'(valid_t - last_t), 64'(exp_lat));
    chk({name, "_nstart"}, 64'(nstart), 64'(exp_blocks));
    chk({name, "_nwork"}, 64'(nwork), 64'(24 * exp_blocks));
    chk({name, "_overlap"}, 64'(nboth), 64'd0);
    if (exp_blocks <= 3 && nstart >= exp_blocks) begin
      chk({name, "_last_start"}, 64'(start_t[exp_blocks-1] - last_t), 64'(exp_ls));
      for (int b = 0; b < exp_blocks; b++) begin
        chk($sformatf("%s_prep%0d", name, b), 64'(prep_at[b]), (b == 0) ? 64'd1 : 64'd0);
        for (int i = 0; i < 16; i++)
          chk($sformatf("%s_x%0d_%0d", name, b, i), xs[b][i], exp_x[b][i]);
      end
    end
    $display("msg %s lvl=%0d words=%0d blocks=%0d latency=%0d", name, lvl, nw, nstart,
             valid_t - last_t);
  endtask

  task automatic setup_empty();
    clear_exp();
    msg[0] = 64'h1122_3344_5566_7788;
    exp_x[0][0] = 64'h40;
  endtask

  initial begin
    int g;
    // reset state
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 64'(in_ready_o), 64'd0);
    chk("rst_start", 64'(core_start_o), 64'd0);
    chk("rst_work", 64'(core_work_o), 64'd0);
    chk("rst_valid", 64'(hash_valid_o), 64'd0);
    chk("rst_hash", hash_o[63:0], 64'd0);
    chk("rst_x0", core_x_o[63:0], 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_ready", 64'(in_ready_o), 64'd1);

    // empty message, l=128
    setup_empty();
    run_msg("empty128", 0, 1, 0, 1, 26, 1, 4, 0);

    // 3-byte message, l=256, digest held 10 cycles
    clear_exp();
    msg[0] = 64'h0000_0000_0003_0201;
    exp_x[0][0] = 64'h0000_0000_4003_0201;
    run_msg("short256", 2, 1, 3, 1, 26, 1, 8, 10);

    // exactly one full block at l=128, pad spills into its own block
    clear_exp();
    for (int i = 0; i < 16; i++) begin
      msg[i] = {32'hA5A5_0000, 32'(i)};
      exp_x[0][i] = {32'hA5A5_0000, 32'(i)};
    end
    exp_x[1][0] = 64'h40;
    run_msg("full128", 0, 16, 8, 2, 52, 27, 4, 0);

    // l=192: 12-word block, then one full word with pad in the same block
    clear_exp();
    for (int i = 0; i < 13; i++) msg[i] = {32'h5A5A_1000, 32'(i)};
    for (int i = 0; i < 12; i++) exp_x[0][i] = {32'h5A5A_1000, 32'(i)};
    exp_x[1][0] = {32'h5A5A_1000, 32'd12};
    exp_x[1][1] = 64'h40;
    run_msg("two192", 1, 13, 8, 2, 26, 1, 6, 0);

    // reset in the middle of RUN
    setup_empty();
    clear_mon();
    send_msg(0, 1, 0);
    g = 0;
    while (nwork < 12 && g < 100) begin
      @(posedge clk_i); #1; g++;
    end
    chk("mid_run_reached", 64'(nwork >= 12), 64'd1);
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_work", 64'(core_work_o), 64'd0);
    chk("arst_ready", 64'(in_ready_o), 64'd0);
    chk("arst_valid", 64'(hash_valid_o), 64'd0);
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("arst_rel_ready", 64'(in_ready_o), 64'd1);
    setup_empty();
    run_msg("after_rst", 0, 1, 0, 1, 26, 1, 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
